// File: rtl/link_eoverp_rx.sv
// Receive side of the E-over-P link: slices the line pair, recovers Manchester bits,
// hunts for preamble + SFD and delivers Last/Error-tagged bytes through an output FIFO.
module link_eoverp_rx #(
    parameter int unsigned HALF_SAMPLES = 4,
    parameter int unsigned PREAMBLE_MIN = 16,
    parameter logic [7:0]  SFD          = 8'hD5,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic       Clock100MhzP,
    input  logic       ResetN,
    input  logic       TIA_568B12,
    input  logic       TIA_568B36,
    output logic [7:0] RxData,
    output logic       RxValid,
    input  logic       RxReady,
    output logic       RxLast,
    output logic       RxError,
    output logic       LinkLocked,
    output logic       OverflowPulse
);

    localparam int unsigned WIN_LO  = (3 * HALF_SAMPLES) / 2;
    localparam int unsigned WIN_HI  = (5 * HALF_SAMPLES) / 2;
    localparam int unsigned LOSS_PH = WIN_HI + 1;
    localparam int unsigned PH_W    = $clog2(LOSS_PH + 1);
    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned CW      = AW + 1;
    localparam int unsigned EW      = 10;

    typedef enum logic [1:0] {HUNT, PREAMBLE, DATA} state_t;

    // Synchronizers, slicer and edge detect: pin to edge_q takes three samples
    logic [1:0] p_sync, n_sync;
    logic       cur_valid_c, cur_lvl_c;
    logic       prev_valid, prev_lvl;
    logic       edge_q, lvl_q, sq_q;

    assign cur_valid_c = p_sync[1] ^ n_sync[1];
    assign cur_lvl_c   = p_sync[1];

    always_ff @(posedge Clock100MhzP or negedge ResetN) begin
        if (!ResetN) begin
            p_sync     <= '0;
            n_sync     <= '0;
            prev_valid <= 1'b0;
            prev_lvl   <= 1'b0;
            edge_q     <= 1'b0;
            lvl_q      <= 1'b0;
            sq_q       <= 1'b0;
        end else begin
            p_sync     <= {p_sync[0], TIA_568B12};
            n_sync     <= {n_sync[0], TIA_568B36};
            prev_valid <= cur_valid_c;
            prev_lvl   <= cur_lvl_c;
            edge_q     <= cur_valid_c & prev_valid & (cur_lvl_c ^ prev_lvl);
            lvl_q      <= cur_lvl_c;
            sq_q       <= ~cur_valid_c;
        end
    end

    // since_q counts samples elapsed since the last accepted edge, including the current one
    state_t          state_q, state_d;
    logic [PH_W-1:0] since_q, since_d;
    logic [7:0]      sr_q, sr_d, pre_cnt_q, pre_cnt_d, byte_q, byte_d, pend_q, pend_d;
    logic            have_prev_q, have_prev_d, prev_bit_q, prev_bit_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic            pend_valid_q, pend_valid_d, locked_q;
    logic            loss_c, bit_ok_c, push_c;
    logic [7:0]      sr_shift_c, byte_shift_c;
    logic [EW-1:0]   push_word_c;

    assign loss_c       = (since_q == PH_W'(LOSS_PH));
    assign bit_ok_c     = edge_q && (since_q >= PH_W'(WIN_LO)) && (since_q <= PH_W'(WIN_HI));
    assign sr_shift_c   = {lvl_q, sr_q[7:1]};
    assign byte_shift_c = {lvl_q, byte_q[7:1]};

    always_ff @(posedge Clock100MhzP or negedge ResetN) begin
        if (!ResetN) begin
            state_q      <= HUNT;
            since_q      <= '0;
            sr_q         <= '0;
            pre_cnt_q    <= '0;
            byte_q       <= '0;
            pend_q       <= '0;
            have_prev_q  <= 1'b0;
            prev_bit_q   <= 1'b0;
            bit_cnt_q    <= '0;
            pend_valid_q <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            since_q      <= since_d;
            sr_q         <= sr_d;
            pre_cnt_q    <= pre_cnt_d;
            byte_q       <= byte_d;
            pend_q       <= pend_d;
            have_prev_q  <= have_prev_d;
            prev_bit_q   <= prev_bit_d;
            bit_cnt_q    <= bit_cnt_d;
            pend_valid_q <= pend_valid_d;
            locked_q     <= (state_d != HUNT);
        end
    end

    always_comb begin
        state_d      = state_q;
        since_d      = since_q;
        sr_d         = sr_q;
        pre_cnt_d    = pre_cnt_q;
        byte_d       = byte_q;
        pend_d       = pend_q;
        have_prev_d  = have_prev_q;
        prev_bit_d   = prev_bit_q;
        bit_cnt_d    = bit_cnt_q;
        pend_valid_d = pend_valid_q;
        push_c       = 1'b0;
        push_word_c  = '0;
        if (!loss_c) since_d = since_q + PH_W'(1);
        case (state_q)
            HUNT: begin
                if (edge_q) begin
                    state_d     = PREAMBLE;
                    since_d     = PH_W'(1);
                    sr_d        = '0;
                    pre_cnt_d   = '0;
                    have_prev_d = 1'b0;
                end
            end
            PREAMBLE: begin
                if (loss_c) begin
                    state_d = HUNT;
                end else if (bit_ok_c) begin
                    since_d     = PH_W'(1);
                    sr_d        = sr_shift_c;
                    prev_bit_d  = lvl_q;
                    have_prev_d = 1'b1;
                    // A repeated bit ends the preamble: either a valid SFD or a restart
                    if (have_prev_q && (lvl_q == prev_bit_q)) begin
                        if ((sr_shift_c == SFD) && (pre_cnt_q >= 8'(PREAMBLE_MIN))) begin
                            state_d      = DATA;
                            bit_cnt_d    = '0;
                            pend_valid_d = 1'b0;
                        end else begin
                            state_d = HUNT;
                        end
                    end else if (have_prev_q && (pre_cnt_q != 8'hFF)) begin
                        pre_cnt_d = pre_cnt_q + 8'd1;
                    end
                end
            end
            DATA: begin
                if (loss_c) begin
                    state_d      = HUNT;
                    pend_valid_d = 1'b0;
                    if (pend_valid_q) begin
                        push_c      = 1'b1;
                        push_word_c = {1'b1, ~sq_q | (bit_cnt_q != 3'd0), pend_q};
                    end
                end else if (bit_ok_c) begin
                    since_d   = PH_W'(1);
                    byte_d    = byte_shift_c;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        pend_d       = byte_shift_c;
                        pend_valid_d = 1'b1;
                        if (pend_valid_q) begin
                            push_c      = 1'b1;
                            push_word_c = {2'b00, pend_q};
                        end
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    // Output FIFO with a registered head entry {last, error, data}
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q, rd_next_c;
    logic [CW-1:0] cnt_q, cnt_next_c;
    logic [EW-1:0] head_q, head_next_c;
    logic          valid_q, ovf_q, full_c, pop_c, wr_en_c;

    assign full_c      = (cnt_q == CW'(FIFO_DEPTH));
    assign pop_c       = valid_q & RxReady;
    assign wr_en_c     = push_c & (~full_c | pop_c);
    assign rd_next_c   = pop_c ? rd_q + AW'(1) : rd_q;
    assign head_next_c = (wr_en_c && (wr_q == rd_next_c)) ? push_word_c : mem_q[rd_next_c];

    always_comb begin
        cnt_next_c = cnt_q;
        if (wr_en_c && !pop_c) cnt_next_c = cnt_q + CW'(1);
        else if (!wr_en_c && pop_c) cnt_next_c = cnt_q - CW'(1);
    end

    always_ff @(posedge Clock100MhzP) begin
        if (wr_en_c) mem_q[wr_q] <= push_word_c;
    end

    always_ff @(posedge Clock100MhzP or negedge ResetN) begin
        if (!ResetN) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            head_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (wr_en_c) wr_q <= wr_q + AW'(1);
            rd_q    <= rd_next_c;
            cnt_q   <= cnt_next_c;
            head_q  <= head_next_c;
            valid_q <= (cnt_next_c != '0);
            ovf_q   <= push_c & full_c & ~pop_c;
        end
    end

    assign RxData        = head_q[7:0];
    assign RxError       = head_q[8];
    assign RxLast        = head_q[9];
    assign RxValid       = valid_q;
    assign LinkLocked    = locked_q;
    assign OverflowPulse = ovf_q;

endmodule
